// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - two-requester arbiter sharing one ALU, valid/ready response return
module alu_share_arb #(
  parameter int WIDTH      = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_zero,
  output logic             resp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_zero
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'b01;

  logic [1:0]       r_state;
  logic             r_last_grant;
  logic             r_gnt;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [1:0]       r_alu_op;
  logic [WIDTH-1:0] r_resp_data;
  logic             r_resp_zero;
  logic             r_resp_err;

  logic             w_pick1;
  logic             w_accept;
  logic             w_resp_hs;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [1:0]       w_op;

  // On contention, round-robin hands the grant to whoever did not win last time.
  always_comb begin
    w_pick1 = 1'b0;
    if (req1_valid && !req0_valid) begin
      w_pick1 = 1'b1;
    end else if (req0_valid && req1_valid) begin
      w_pick1 = (FIXED_PRIO == 0) && !r_last_grant;
    end
  end

  assign w_accept  = (r_state == S_IDLE) && (req0_valid || req1_valid);
  assign w_a       = w_pick1 ? req1_a  : req0_a;
  assign w_b       = w_pick1 ? req1_b  : req0_b;
  assign w_op      = w_pick1 ? req1_op : req0_op;
  assign w_resp_hs = (r_state == S_RESP) && (r_gnt ? resp1_ready : resp0_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_gnt        <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= 2'b00;
      r_resp_data  <= '0;
      r_resp_zero  <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_gnt        <= w_pick1;
            r_last_grant <= w_pick1;
            // Reserved opcode never reaches the ALU: it would return a stale result.
            if (w_op == OP_RSVD) begin
              r_resp_data <= '0;
              r_resp_zero <= 1'b0;
              r_resp_err  <= 1'b1;
              r_state     <= S_RESP;
            end else begin
              r_alu_a  <= w_a;
              r_alu_b  <= w_b;
              r_alu_op <= w_op;
              r_state  <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          r_resp_data <= alu_c;
          r_resp_zero <= alu_zero;
          r_resp_err  <= 1'b0;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (w_resp_hs) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req0_ready  = w_accept && !w_pick1;
  assign req1_ready  = w_accept && w_pick1;
  assign resp0_valid = (r_state == S_RESP) && !r_gnt;
  assign resp1_valid = (r_state == S_RESP) && r_gnt;
  assign resp_data   = r_resp_data;
  assign resp_zero   = r_resp_zero;
  assign resp_err    = r_resp_err;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_op      = r_alu_op;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - self-checking bench for alu_share_arb with scoreboard and ALU model
module tb_alu_share_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_op, req1_op;
  logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [31:0] resp_data;
  logic        resp_zero, resp_err;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [1:0]  alu_op;
  logic        alu_zero;

  alu_share_arb #(.WIDTH(32), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_data(resp_data), .resp_zero(resp_zero), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c), .alu_zero(alu_zero)
  );

  // ALU model: OR / ADD / SUB, Zero flags A==B
  always @* begin
    case (alu_op)
      2'b00:   alu_c = alu_a | alu_b;
      2'b10:   alu_c = alu_a + alu_b;
      2'b11:   alu_c = alu_a - alu_b;
      default: alu_c = 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_a == alu_b);
  end

  // Second instance in fixed-priority mode, permanently contended
  logic        p_req0_ready, p_req1_ready, p_resp0_valid, p_resp1_valid;
  logic [31:0] p_resp_data, p_alu_a, p_alu_b;
  logic        p_resp_zero, p_resp_err;
  logic [1:0]  p_alu_op;
  int          p_grants0 = 0, p_grants1 = 0;

  alu_share_arb #(.WIDTH(32), .FIXED_PRIO(1)) dut_fixed (
    .clk(clk), .rst(rst),
    .req0_valid(!rst), .req0_ready(p_req0_ready), .req0_a(32'd3), .req0_b(32'd4), .req0_op(2'b10),
    .req1_valid(!rst), .req1_ready(p_req1_ready), .req1_a(32'd5), .req1_b(32'd6), .req1_op(2'b10),
    .resp0_valid(p_resp0_valid), .resp0_ready(1'b1),
    .resp1_valid(p_resp1_valid), .resp1_ready(1'b1),
    .resp_data(p_resp_data), .resp_zero(p_resp_zero), .resp_err(p_resp_err),
    .alu_a(p_alu_a), .alu_b(p_alu_b), .alu_op(p_alu_op),
    .alu_c(p_alu_a + p_alu_b), .alu_zero(p_alu_a == p_alu_b)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (p_req0_ready) p_grants0++;
      if (p_req1_ready) p_grants1++;
    end
  end

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] d;
    logic        z;
    logic        e;
  } vec_t;

  typedef struct {
    int          r;
    logic [31:0] d;
    logic        z;
    logic        e;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   errors = 0;
  int   checks = 0;
  int   w, w0, w1, w2;
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every response handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (resp0_valid && resp1_valid) chk("both_resp_valid", 32'd1, 32'd0);
      if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("resp_requester", resp1_valid ? 32'd1 : 32'd0, mon_e.r);
          chk("resp_data", resp_data, mon_e.d);
          chk("resp_zero", {31'd0, resp_zero}, {31'd0, mon_e.z});
          chk("resp_err", {31'd0, resp_err}, {31'd0, mon_e.e});
        end
      end
    end
  end

  task automatic issue(input int r, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       input logic [31:0] d, input logic z, input logic e, output int waits);
    exp_t x;
    logic rdy;
    @(posedge clk); #1;
    if (r == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
    else        begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
    waits = 0;
    rdy = 1'b0;
    while (!rdy && waits < 60) begin
      @(negedge clk);
      rdy = (r == 0) ? req0_ready : req1_ready;
      if (!rdy) waits++;
    end
    if (!rdy) begin
      chk("accept_timeout", 32'd1, 32'd0);
    end else begin
      x.r = r; x.d = d; x.z = z; x.e = e;
      sb.push_back(x);
      grant_log.push_back(r);
    end
    @(posedge clk); #1;
    if (r == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{0, 32'h0000_0005, 32'h0000_0003, 2'b10, 32'h0000_0008, 1'b0, 1'b0};
    vecs[1] = '{1, 32'h0000_0000, 32'h0000_0001, 2'b11, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[2] = '{1, 32'h1234_5678, 32'h1234_5678, 2'b11, 32'h0000_0000, 1'b1, 1'b0};
    vecs[3] = '{0, 32'h0000_00F0, 32'h0000_0F00, 2'b00, 32'h0000_0FF0, 1'b0, 1'b0};
    vecs[4] = '{1, 32'h0000_0001, 32'h0000_0001, 2'b10, 32'h0000_0002, 1'b1, 1'b0};
    vecs[5] = '{0, 32'hFFFF_FFFF, 32'h0000_0001, 2'b10, 32'h0000_0000, 1'b0, 1'b0};
    vecs[6] = '{1, 32'h8000_0000, 32'h7FFF_FFFF, 2'b00, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[7] = '{0, 32'h0000_0007, 32'h0000_0009, 2'b01, 32'h0000_0000, 1'b0, 1'b1};

    rst = 1'b1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_resp_valids", {30'd0, resp0_valid, resp1_valid}, 32'd0);
    chk("rst_readies", {30'd0, req0_ready, req1_ready}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", {30'd0, alu_op}, 32'd0);
    chk("rst_resp", {resp_data[29:0], resp_zero, resp_err}, 32'd0);

    // Single ADD with latency check
    issue(0, 32'd5, 32'd3, 2'b10, 32'd8, 1'b0, 1'b0, w);
    chk("t1_ready_same_cycle", w, 32'd0);
    @(negedge clk);
    chk("t1_exec_no_valid", {31'd0, resp0_valid}, 32'd0);
    chk("t1_alu_a", alu_a, 32'd5);
    chk("t1_alu_op", {30'd0, alu_op}, 32'd2);
    @(negedge clk);
    chk("t1_resp0_valid", {31'd0, resp0_valid}, 32'd1);
    chk("t1_data", resp_data, 32'd8);
    drain();

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].d, vecs[i].z, vecs[i].e, w);
    end
    drain();

    // Reserved opcode: no EXEC cycle, ALU registers untouched
    issue(1, 32'd4, 32'd4, 2'b11, 32'd0, 1'b1, 1'b0, w);
    issue(0, 32'd7, 32'd9, 2'b01, 32'd0, 1'b0, 1'b1, w);
    @(negedge clk);
    chk("t4_resp0_valid_next", {31'd0, resp0_valid}, 32'd1);
    chk("t4_err", {31'd0, resp_err}, 32'd1);
    chk("t4_alu_op_kept", {30'd0, alu_op}, 32'd3);
    chk("t4_alu_a_kept", alu_a, 32'd4);
    drain();

    // Round-robin contention from reset
    do_reset();
    grant_log.delete();
    fork
      for (int k = 0; k < 3; k++) issue(0, 32'h0000_00F0, 32'h0000_0F00, 2'b00, 32'h0000_0FF0, 1'b0, 1'b0, w0);
      for (int k = 0; k < 3; k++) issue(1, 32'd1, 32'd1, 2'b10, 32'd2, 1'b1, 1'b0, w1);
    join
    drain();
    chk("t3_grant_count", grant_log.size(), 32'd6);
    for (int k = 0; k < 6 && k < grant_log.size(); k++) chk($sformatf("t3_grant_%0d", k), grant_log[k], k % 2);

    // Back-pressure with a pending req0
    resp1_ready = 1'b0;
    issue(1, 32'd2, 32'd3, 2'b10, 32'd5, 1'b0, 1'b0, w);
    fork
      issue(0, 32'h10, 32'h20, 2'b10, 32'h30, 1'b0, 1'b0, w2);
    join_none
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_resp1_valid_held", {31'd0, resp1_valid}, 32'd1);
      chk("t5_data_held", resp_data, 32'd5);
      chk("t5_req0_blocked", {31'd0, req0_ready}, 32'd0);
    end
    @(posedge clk); #1;
    resp1_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_req0_accepted", {31'd0, req0_ready}, 32'd1);
    wait fork;
    drain();

    // Valid dropped outside IDLE: no grant
    grant_log.delete();
    issue(0, 32'd1, 32'd2, 2'b00, 32'd3, 1'b0, 1'b0, w);
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_op = 2'b10;
    @(negedge clk);
    chk("t7_req1_not_ready_exec", {31'd0, req1_ready}, 32'd0);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("t7_no_extra_grant", grant_log.size(), 32'd1);

    // Reset during EXEC aborts the transaction
    issue(0, 32'd9, 32'd9, 2'b11, 32'd0, 1'b1, 1'b0, w);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("t6_resp_valids", {30'd0, resp0_valid, resp1_valid}, 32'd0);
    chk("t6_alu_a", alu_a, 32'd0);
    chk("t6_alu_b", alu_b, 32'd0);
    chk("t6_alu_op", {30'd0, alu_op}, 32'd0);
    repeat (3) @(negedge clk);
    grant_log.delete();
    fork
      issue(0, 32'd6, 32'd1, 2'b11, 32'd5, 1'b0, 1'b0, w0);
      issue(1, 32'd6, 32'd2, 2'b10, 32'd8, 1'b0, 1'b0, w1);
    join
    drain();
    chk("t6_first_grant_req0", (grant_log.size() > 0) ? grant_log[0] : 32'd99, 32'd0);

    chk("fixed_prio_req1_grants", p_grants1, 32'd0);
    chk("fixed_prio_req0_grants", (p_grants0 > 5) ? 32'd1 : 32'd0, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
